refresh_scheduler: RTL and testbench

Parametrised DRAM refresh scheduler; replaces the fixed-period refresh strobe. Generates refresh ticks from a run-time programmable interval and accumulates owed refreshes in a saturating pending counter (postponement). Issues refreshes to the memory controller through a REQ/ACK handshake: opportunistically when the controller is idle, forcibly once the backlog reaches an urgency level. Sits between the clock domain's reset logic and the SDRAM controller's command arbiter.

---
 rtl/refresh_scheduler.sv | 131 +++++++++++++
 tb/tb_refresh_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/refresh_scheduler.sv
// refresh_scheduler
// DRAM refresh scheduler. A programmable down-counter produces refresh ticks,
// owed refreshes accumulate in a saturating pending counter, and a small
// request FSM hands them to the SDRAM controller over a REQ/ACK handshake:
// opportunistically while the controller is idle, or forcibly once the
// backlog reaches the urgency level.

module refresh_scheduler #(
   parameter int  INTERVAL_W   = 11,
   parameter int  MAX_PENDING  = 8,
   parameter int  URGENT_LEVEL = 6,
   localparam int PEND_W       = $clog2(MAX_PENDING + 1)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  ENABLE,
   input  logic [INTERVAL_W-1:0] INTERVAL,
   input  logic                  IDLE,
   input  logic                  REFRESH_ACK,
   input  logic                  OVERFLOW_CLR,
   output logic                  REFRESH_REQ,
   output logic                  REFRESH_URGENT,
   output logic [PEND_W-1:0]     PENDING,
   output logic                  OVERFLOW
);

   typedef enum logic [1:0] {
      S_WAIT = 2'd0,
      S_REQ  = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   localparam logic [PEND_W-1:0] PEND_MAX    = PEND_W'(MAX_PENDING);
   localparam logic [PEND_W-1:0] PEND_URGENT = PEND_W'(URGENT_LEVEL);

   logic [INTERVAL_W-1:0] cnt;
   logic [PEND_W-1:0]     pending;
   logic                  overflow;
   logic                  tick;
   logic                  ack_accepted;
   logic                  overflow_set;
   logic                  urgent;
   state_t                state;
   state_t                state_next;

   // A tick is the enabled edge on which the interval counter has run out.
   // An ACK only counts while a request is actually outstanding.
   assign tick         = ENABLE && (cnt == '0);
   assign ack_accepted = REFRESH_ACK && (state == S_REQ);
   assign overflow_set = tick && !ack_accepted && (pending == PEND_MAX);
   assign urgent       = (pending >= PEND_URGENT);

   // Interval down-counter; INTERVAL is only picked up at reload so a
   // mid-period reprogram lets the running period finish.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt <= '0;
      end else if (!ENABLE) begin
         cnt <= INTERVAL;
      end else if (cnt == '0) begin
         cnt <= INTERVAL;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   // Owed-refresh counter: ticks add, accepted ACKs subtract, a coincident
   // tick and ACK cancel, and ticks arriving at saturation are dropped.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pending <= '0;
      end else if (tick && !ack_accepted) begin
         if (pending != PEND_MAX) begin
            pending <= pending + 1'b1;
         end
      end else if (ack_accepted && !tick) begin
         pending <= pending - 1'b1;
      end
   end

   // Sticky lost-tick flag; a new loss on the clearing edge keeps it set.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         overflow <= 1'b0;
      end else if (overflow_set) begin
         overflow <= 1'b1;
      end else if (OVERFLOW_CLR) begin
         overflow <= 1'b0;
      end
   end

   // Request FSM state register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= S_WAIT;
      end else begin
         state <= state_next;
      end
   end

   // Request FSM next state: request when something is owed and either the
   // controller is idle or the backlog is urgent, hold until ACK, then force
   // one low cycle before the next request.
   always_comb begin
      state_next = state;
      case (state)
         S_WAIT: begin
            if ((pending != '0) && (IDLE || urgent)) begin
               state_next = S_REQ;
            end
         end
         S_REQ: begin
            if (REFRESH_ACK) begin
               state_next = S_GAP;
            end
         end
         S_GAP: begin
            state_next = S_WAIT;
         end
         default: begin
            state_next = S_WAIT;
         end
      endcase
   end

   assign REFRESH_REQ    = (state == S_REQ);
   assign REFRESH_URGENT = urgent;
   assign PENDING        = pending;
   assign OVERFLOW       = overflow;

endmodule

// File: tb/tb_refresh_scheduler.sv
// tb_refresh_scheduler
// Scoreboard bench: every driven cycle a reference model pushes the expected
// outputs for the following edge, which are popped and compared once the DUT
// has clocked. Directed checks cover async reset, request spacing,
// saturation/overflow priority, tick/ACK coincidence and reprogramming.

module tb_refresh_scheduler;

   localparam int MAX_P  = 8;
   localparam int URG_LV = 6;

   logic        CLK;
   logic        RST;
   logic        ENABLE;
   logic [10:0] INTERVAL;
   logic        IDLE;
   logic        REFRESH_ACK;
   logic        OVERFLOW_CLR;
   logic        REFRESH_REQ;
   logic        REFRESH_URGENT;
   logic [3:0]  PENDING;
   logic        OVERFLOW;

   typedef struct packed {
      logic       req;
      logic       urg;
      logic [3:0] pend;
      logic       ovf;
   } expect_t;

   expect_t sbQueue[$];
   int      riseCycles[$];

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;
   int ackMode  = 0;
   int mCnt     = 0;
   int mPend    = 0;
   int mState   = 0;
   bit mOvf     = 0;
   bit prevReq  = 0;

   refresh_scheduler dut (
      .CLK            (CLK),
      .RST            (RST),
      .ENABLE         (ENABLE),
      .INTERVAL       (INTERVAL),
      .IDLE           (IDLE),
      .REFRESH_ACK    (REFRESH_ACK),
      .OVERFLOW_CLR   (OVERFLOW_CLR),
      .REFRESH_REQ    (REFRESH_REQ),
      .REFRESH_URGENT (REFRESH_URGENT),
      .PENDING        (PENDING),
      .OVERFLOW       (OVERFLOW)
   );

   // Free-running clock, period 10.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Hard stop in case something wedges the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         failures++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycle, observed, expected);
      end
   endtask

   task automatic resetModel();
      mCnt   = 0;
      mPend  = 0;
      mState = 0;
      mOvf   = 0;
      sbQueue.delete();
   endtask

   // Drives ACK according to ackMode, predicts the next edge, clocks the DUT
   // and compares against the popped expectation.
   task automatic applyStimulus();
      bit      tickNow;
      bit      accNow;
      bit      lost;
      int      nCnt;
      int      nPend;
      int      nState;
      bit      nOvf;
      expect_t e;
      expect_t got;

      tickNow = ENABLE && (mCnt == 0);
      case (ackMode)
         1:       REFRESH_ACK = (mState == 1);
         2:       REFRESH_ACK = (mState == 1) && tickNow;
         3:       REFRESH_ACK = (mState != 1);
         4:       REFRESH_ACK = 1'b1;
         default: REFRESH_ACK = 1'b0;
      endcase
      accNow = REFRESH_ACK && (mState == 1);

      nCnt = (!ENABLE || mCnt == 0) ? int'(INTERVAL) : mCnt - 1;
      nPend = mPend;
      lost  = 0;
      if (tickNow && !accNow) begin
         if (mPend >= MAX_P) lost = 1;
         else nPend = mPend + 1;
      end else if (accNow && !tickNow) begin
         nPend = mPend - 1;
      end
      nOvf = lost ? 1'b1 : (OVERFLOW_CLR ? 1'b0 : mOvf);
      if (mState == 0) nState = (mPend > 0 && (IDLE || mPend >= URG_LV)) ? 1 : 0;
      else if (mState == 1) nState = REFRESH_ACK ? 2 : 1;
      else nState = 0;

      e.req  = (nState == 1);
      e.urg  = (nPend >= URG_LV);
      e.pend = 4'(nPend);
      e.ovf  = nOvf;
      sbQueue.push_back(e);
      mCnt   = nCnt;
      mPend  = nPend;
      mState = nState;
      mOvf   = nOvf;

      @(posedge CLK);
      #1;
      cycle++;
      got = sbQueue.pop_front();
      checkOutput("req",      REFRESH_REQ,    got.req);
      checkOutput("urgent",   REFRESH_URGENT, got.urg);
      checkOutput("pending",  PENDING,        got.pend);
      checkOutput("overflow", OVERFLOW,       got.ovf);
      if (REFRESH_REQ && !prevReq) riseCycles.push_back(cycle);
      prevReq = REFRESH_REQ;
   endtask

   // Scenario sequence.
   initial begin
      int periods[4];

      RST          = 1'b1;
      ENABLE       = 1'b0;
      IDLE         = 1'b0;
      REFRESH_ACK  = 1'b0;
      OVERFLOW_CLR = 1'b0;
      INTERVAL     = 11'd9;
      #2;
      checkOutput("reset-req",      REFRESH_REQ,    0);
      checkOutput("reset-urgent",   REFRESH_URGENT, 0);
      checkOutput("reset-pending",  PENDING,        0);
      checkOutput("reset-overflow", OVERFLOW,       0);
      @(posedge CLK);
      #4;
      RST = 1'b0;
      resetModel();

      // Steady state: tick every 10, fast ACK, requests 10 apart.
      $display("[TB] steady state");
      ENABLE  = 1'b1;
      IDLE    = 1'b1;
      ackMode = 1;
      riseCycles.delete();
      repeat (50) applyStimulus();
      checkOutput("steady-rises", riseCycles.size(), 5);
      for (int i = 1; i < 5 && i < riseCycles.size(); i++)
         checkOutput("steady-period", riseCycles[i] - riseCycles[i-1], 10);

      // Settle, then postpone with the controller busy until saturation.
      $display("[TB] postponement and saturation");
      ENABLE = 1'b0;
      repeat (6) applyStimulus();
      IDLE     = 1'b0;
      ackMode  = 0;
      INTERVAL = 11'd3;
      ENABLE   = 1'b1;
      for (int i = 0; i < 100 && !mOvf; i++) applyStimulus();
      checkOutput("sat-pending",  PENDING,     8);
      checkOutput("sat-overflow", OVERFLOW,    1);
      checkOutput("sat-req",      REFRESH_REQ, 1);
      for (int i = 0; i < 10 && !(ENABLE && mCnt == 0); i++) applyStimulus();
      OVERFLOW_CLR = 1'b1;
      applyStimulus();
      OVERFLOW_CLR = 1'b0;
      checkOutput("clr-vs-lost-tick", OVERFLOW, 1);
      OVERFLOW_CLR = 1'b1;
      applyStimulus();
      OVERFLOW_CLR = 1'b0;
      checkOutput("clr-later", OVERFLOW, 0);

      ENABLE  = 1'b0;
      IDLE    = 1'b1;
      ackMode = 1;
      riseCycles.delete();
      repeat (30) applyStimulus();
      checkOutput("drain-rises",   riseCycles.size(), 7);
      checkOutput("drain-pending", PENDING,           0);

      // Coincident tick and ACK with two owed refreshes.
      $display("[TB] coincidence");
      IDLE     = 1'b0;
      ackMode  = 0;
      INTERVAL = 11'd4;
      repeat (2) applyStimulus();
      ENABLE = 1'b1;
      for (int i = 0; i < 30 && mPend < 2; i++) applyStimulus();
      checkOutput("coin-pre-pending", PENDING, 2);
      IDLE    = 1'b1;
      ackMode = 2;
      begin
         bit found = 0;
         for (int i = 0; i < 20 && !found; i++) begin
            if (mState == 1 && ENABLE && mCnt == 0 && mPend == 2) found = 1;
            applyStimulus();
         end
      end
      checkOutput("coin-pending", PENDING,     2);
      checkOutput("coin-gap-req", REFRESH_REQ, 0);
      ackMode = 0;
      applyStimulus();
      checkOutput("coin-wait-req", REFRESH_REQ, 0);
      applyStimulus();
      checkOutput("coin-rereq", REFRESH_REQ, 1);

      ENABLE  = 1'b0;
      IDLE    = 1'b0;
      ackMode = 1;
      repeat (2) applyStimulus();
      ackMode = 3;
      repeat (5) applyStimulus();
      checkOutput("ack-low-pending", PENDING,     1);
      checkOutput("ack-low-req",     REFRESH_REQ, 0);

      // Disabled counter still drains; then reprogram mid-period.
      $display("[TB] enable and reprogram");
      IDLE    = 1'b1;
      ackMode = 1;
      repeat (50) applyStimulus();
      checkOutput("disabled-pending", PENDING, 0);
      INTERVAL = 11'd9;
      ENABLE   = 1'b1;
      riseCycles.delete();
      for (int i = 0; i < 40 && riseCycles.size() < 2; i++) applyStimulus();
      repeat (3) applyStimulus();
      INTERVAL = 11'd4;
      for (int i = 0; i < 60 && riseCycles.size() < 5; i++) applyStimulus();
      checkOutput("reprog-rises", riseCycles.size(), 5);
      periods = '{10, 10, 5, 5};
      for (int i = 1; i < 5 && i < riseCycles.size(); i++)
         checkOutput("reprog-period", riseCycles[i] - riseCycles[i-1], periods[i-1]);

      // Asynchronous reset in the middle of a handshake.
      $display("[TB] async reset mid-handshake");
      ENABLE = 1'b0;
      repeat (4) applyStimulus();
      IDLE     = 1'b0;
      ackMode  = 0;
      INTERVAL = 11'd1;
      ENABLE   = 1'b1;
      for (int i = 0; i < 20 && mPend < 3; i++) applyStimulus();
      ENABLE = 1'b0;
      IDLE   = 1'b1;
      applyStimulus();
      checkOutput("pre-reset-req",     REFRESH_REQ, 1);
      checkOutput("pre-reset-pending", PENDING,     3);
      #2;
      RST = 1'b1;
      #1;
      checkOutput("async-req",      REFRESH_REQ,    0);
      checkOutput("async-urgent",   REFRESH_URGENT, 0);
      checkOutput("async-pending",  PENDING,        0);
      checkOutput("async-overflow", OVERFLOW,       0);
      REFRESH_ACK = 1'b1;
      @(posedge CLK);
      #1;
      cycle++;
      checkOutput("held-reset-req",     REFRESH_REQ, 0);
      checkOutput("held-reset-pending", PENDING,     0);
      #3;
      RST = 1'b0;
      resetModel();
      prevReq = 1'b0;
      ackMode = 4;
      repeat (3) applyStimulus();
      checkOutput("post-reset-pending", PENDING,     0);
      checkOutput("post-reset-req",     REFRESH_REQ, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
